// File: rtl/wb_bridge_nway.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : wb_bridge_nway                                                |
// | Purpose  : Wishbone classic 1-to-N bridge. One upstream slave port is    |
// |            decoded by a base-address match plus a port-index field and   |
// |            forwarded to one of NUM_PORTS downstream master ports. One    |
// |            transfer is outstanding at a time. Out-of-range port indices  |
// |            (and, optionally, downstream timeouts) are answered locally   |
// |            with 32'hDEAD_BEEF and a one-cycle err_o pulse.               |
// | Ports    : wb_clk_i / wb_rst_ni     clock, async active-low reset        |
// |            wbs_*                    upstream request / response          |
// |            wbm_stb_o / wbm_cyc_o    per-port strobe/cycle (one-hot or 0) |
// |            wbm_we/sel/dat/adr_o     shared downstream request fields     |
// |            wbm_ack_i / wbm_dat_i    per-port response (port k: [32k+:32])|
// |            err_o                    error-terminated transfer pulse      |
// |            vccd1 / vssd1            power pins (USE_POWER_PINS only)     |
// | Options  : WB_BRIDGE_TIMEOUT_EN  enables the downstream wait timeout     |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module wb_bridge_nway #(
  parameter int          NUM_PORTS       = 4,
  parameter int          PORT_ADDR_WIDTH = 10,
  parameter int          SEL_LSB         = 16,
  parameter logic [31:0] BASE_ADDR       = 32'h3000_0000,
  parameter int          TIMEOUT_CYCLES  = 64
) (
`ifdef USE_POWER_PINS
  inout  wire                          vccd1,
  inout  wire                          vssd1,
`endif
  input  logic                         wb_clk_i,
  input  logic                         wb_rst_ni,
  input  logic                         wbs_stb_i,
  input  logic                         wbs_cyc_i,
  input  logic                         wbs_we_i,
  input  logic [3:0]                   wbs_sel_i,
  input  logic [31:0]                  wbs_dat_i,
  input  logic [31:0]                  wbs_adr_i,
  output logic                         wbs_ack_o,
  output logic [31:0]                  wbs_dat_o,
  output logic [NUM_PORTS-1:0]         wbm_stb_o,
  output logic [NUM_PORTS-1:0]         wbm_cyc_o,
  output logic                         wbm_we_o,
  output logic [3:0]                   wbm_sel_o,
  output logic [31:0]                  wbm_dat_o,
  output logic [PORT_ADDR_WIDTH-1:0]   wbm_adr_o,
  input  logic [NUM_PORTS-1:0]         wbm_ack_i,
  input  logic [32*NUM_PORTS-1:0]      wbm_dat_i,
  output logic                         err_o
);

  localparam int                c_SELW     = $clog2(NUM_PORTS);
  localparam int                c_BASE_LSB = SEL_LSB + c_SELW;
  localparam logic [c_SELW:0]   c_NPORTS   = (c_SELW + 1)'(NUM_PORTS);
  localparam logic [31:0]       c_ERR_DATA = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FWD  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t                       r_state;
  state_t                       w_state_nxt;

  logic                         r_rst_n;
  logic                         r_ack;
  logic                         r_err;
  logic                         r_resp_err;
  logic [31:0]                  r_rdat;
  logic [NUM_PORTS-1:0]         r_strobe;
  logic                         r_we;
  logic [3:0]                   r_sel;
  logic [31:0]                  r_wdat;
  logic [PORT_ADDR_WIDTH-1:0]   r_adr;
  logic [c_SELW-1:0]            r_idx;

  logic                         w_req;
  logic [c_SELW-1:0]            w_idx;
  logic                         w_idx_ok;
  logic [NUM_PORTS-1:0]         w_onehot;
  logic                         w_sel_ack;
  logic [31:0]                  w_sel_dat;
  logic                         w_accept;
  logic                         w_bad;
  logic                         w_done;
  logic                         w_abort;
  logic                         w_tmo;

  // Only part of the upstream address is decoded.
  wire w_unused_ok = &{1'b0, wbs_adr_i};

  // Reset asserts asynchronously and releases on a clock edge, so the first
  // request can be sampled on the second edge after wb_rst_ni rises.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) r_rst_n <= 1'b0;
    else            r_rst_n <= 1'b1;
  end

  // The registered ack blocks re-sampling the same upstream request in the
  // cycle the master is still holding stb while it observes the ack.
  assign w_req    = wbs_stb_i & wbs_cyc_i & ~r_ack &
                    (wbs_adr_i[31:c_BASE_LSB] == BASE_ADDR[31:c_BASE_LSB]);
  assign w_idx    = wbs_adr_i[SEL_LSB +: c_SELW];
  assign w_idx_ok = ({1'b0, w_idx} < c_NPORTS);

  always_comb begin
    w_onehot  = '0;
    w_sel_ack = 1'b0;
    w_sel_dat = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      w_onehot[k] = (w_idx == c_SELW'(k));
      if (r_idx == c_SELW'(k)) begin
        w_sel_ack = wbm_ack_i[k];
        w_sel_dat = wbm_dat_i[32*k +: 32];
      end
    end
  end

`ifdef WB_BRIDGE_TIMEOUT_EN
  localparam logic [9:0] c_TMO_LAST = 10'(TIMEOUT_CYCLES - 1);
  logic [9:0]            r_tmo_cnt;

  // Counts FWD cycles; value k means this is the (k+1)-th FWD cycle.
  always_ff @(posedge wb_clk_i or negedge r_rst_n) begin
    if (!r_rst_n)                r_tmo_cnt <= '0;
    else if (w_accept)           r_tmo_cnt <= '0;
    else if (r_state == S_FWD)   r_tmo_cnt <= r_tmo_cnt + 10'd1;
  end
`endif

  always_ff @(posedge wb_clk_i or negedge r_rst_n) begin
    if (!r_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_bad       = 1'b0;
    w_done      = 1'b0;
    w_abort     = 1'b0;
    w_tmo       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_req) begin
          w_accept = 1'b1;
          if (w_idx_ok) begin
            w_state_nxt = S_FWD;
          end else begin
            w_bad       = 1'b1;
            w_state_nxt = S_RESP;
          end
        end
      end
      S_FWD: begin
        // An upstream abort wins over a same-cycle downstream ack.
        if (!wbs_cyc_i) begin
          w_abort     = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (w_sel_ack) begin
          w_done      = 1'b1;
          w_state_nxt = S_RESP;
        end
`ifdef WB_BRIDGE_TIMEOUT_EN
        else if (r_tmo_cnt == c_TMO_LAST) begin
          w_tmo       = 1'b1;
          w_state_nxt = S_RESP;
        end
`endif
      end
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge r_rst_n) begin
    if (!r_rst_n) begin
      r_ack      <= 1'b0;
      r_err      <= 1'b0;
      r_resp_err <= 1'b0;
      r_rdat     <= '0;
      r_strobe   <= '0;
      r_we       <= 1'b0;
      r_sel      <= '0;
      r_wdat     <= '0;
      r_adr      <= '0;
      r_idx      <= '0;
    end else begin
      r_ack <= (r_state == S_RESP);
      r_err <= (r_state == S_RESP) & r_resp_err;

      if (w_accept) begin
        r_we       <= wbs_we_i;
        r_sel      <= wbs_sel_i;
        r_wdat     <= wbs_dat_i;
        r_adr      <= wbs_adr_i[PORT_ADDR_WIDTH-1:0];
        r_idx      <= w_idx;
        r_resp_err <= w_bad;
        if (w_bad) r_rdat   <= c_ERR_DATA;
        else       r_strobe <= w_onehot;
      end

      if (w_done | w_abort | w_tmo) r_strobe <= '0;

      if (w_done) r_rdat <= r_we ? 32'd0 : w_sel_dat;

      if (w_tmo) begin
        r_rdat     <= c_ERR_DATA;
        r_resp_err <= 1'b1;
      end
    end
  end

  assign wbs_ack_o = r_ack;
  assign wbs_dat_o = r_rdat;
  assign wbm_stb_o = r_strobe;
  assign wbm_cyc_o = r_strobe;
  assign wbm_we_o  = r_we;
  assign wbm_sel_o = r_sel;
  assign wbm_dat_o = r_wdat;
  assign wbm_adr_o = r_adr;
  assign err_o     = r_err;

endmodule
`default_nettype wire

// File: tb/tb_wb_bridge_nway.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_wb_bridge_nway                                             |
// | Purpose  : Self-checking bench for wb_bridge_nway. Upstream transfers    |
// |            are compared with a memory-level model of the downstream     |
// |            slaves; a second instance with three ports covers the        |
// |            out-of-range index and base-mismatch cases.                  |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_wb_bridge_nway;

  logic         clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         stb, cyc, we;
  logic [3:0]   sel;
  logic [31:0]  dat, adr;

  logic         ack_o;
  logic [31:0]  dat_o;
  logic [3:0]   m_stb, m_cyc;
  logic         m_we;
  logic [3:0]   m_sel;
  logic [31:0]  m_dat;
  logic [9:0]   m_adr;
  logic [3:0]   m_ack;
  logic [127:0] m_dat_i;
  logic         err;

  logic         stb3, cyc3;
  logic         ack3;
  logic [31:0]  dat3;
  logic [2:0]   m3_stb, m3_cyc;
  logic         m3_we;
  logic [3:0]   m3_sel;
  logic [31:0]  m3_dat;
  logic [9:0]   m3_adr;
  logic [2:0]   m3_ack;
  logic [95:0]  m3_dat_i;
  logic         err3;

  wb_bridge_nway #(.NUM_PORTS(4)) u_dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n),
    .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we), .wbs_sel_i(sel),
    .wbs_dat_i(dat), .wbs_adr_i(adr), .wbs_ack_o(ack_o), .wbs_dat_o(dat_o),
    .wbm_stb_o(m_stb), .wbm_cyc_o(m_cyc), .wbm_we_o(m_we), .wbm_sel_o(m_sel),
    .wbm_dat_o(m_dat), .wbm_adr_o(m_adr), .wbm_ack_i(m_ack), .wbm_dat_i(m_dat_i),
    .err_o(err)
  );

  wb_bridge_nway #(.NUM_PORTS(3)) u_dut3 (
    .wb_clk_i(clk), .wb_rst_ni(rst_n),
    .wbs_stb_i(stb3), .wbs_cyc_i(cyc3), .wbs_we_i(we), .wbs_sel_i(sel),
    .wbs_dat_i(dat), .wbs_adr_i(adr), .wbs_ack_o(ack3), .wbs_dat_o(dat3),
    .wbm_stb_o(m3_stb), .wbm_cyc_o(m3_cyc), .wbm_we_o(m3_we), .wbm_sel_o(m3_sel),
    .wbm_dat_o(m3_dat), .wbm_adr_o(m3_adr), .wbm_ack_i(m3_ack), .wbm_dat_i(m3_dat_i),
    .err_o(err3)
  );

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  // Upstream view of slave contents (model) and the slaves' own storage.
  logic [31:0] model_mem [4][16];
  logic [31:0] slave_mem [4][16];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] bmask(input logic [3:0] s);
    return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
  endfunction

  function automatic logic [31:0] mk_adr(input int p, input logic [9:0] lo);
    return {14'h0C00, 2'(p), 6'($urandom), lo};
  endfunction

  // One complete upstream transfer with a downstream slave that acks after
  // dly FWD cycles; unselected ports raise spurious acks throughout.
  task automatic xfer(input logic [31:0] a, input logic w, input logic [31:0] d,
                      input logic [3:0] s, input int dly);
    int          p, ai;
    logic [3:0]  oh;
    logic [31:0] m, exp_d;
    p  = int'(a[17:16]);
    ai = int'(a[3:0]);
    oh = 4'(1 << p);
    m  = bmask(s);
    if (w) begin
      model_mem[p][ai] = (model_mem[p][ai] & ~m) | (d & m);
      exp_d = 32'd0;
    end else begin
      exp_d = model_mem[p][ai];
    end
    @(negedge clk);
    stb = 1'b1; cyc = 1'b1; we = w; sel = s; dat = d; adr = a;
    @(negedge clk);
    chk("fwd_stb",  32'(m_stb), 32'(oh));
    chk("fwd_cyc",  32'(m_cyc), 32'(oh));
    chk("fwd_adr",  32'(m_adr), 32'(a[9:0]));
    chk("fwd_ctl",  {23'd0, m_we, m_sel, 4'd0}, {23'd0, w, s, 4'd0});
    chk("fwd_dat",  m_dat, d);
    // Upstream changes during FWD must not reach the downstream fields.
    adr = ~a; dat = ~d; sel = ~s; we = ~w;
    for (int i = 0; i < dly; i++) begin
      m_ack   = 4'($urandom) & ~oh;
      m_dat_i = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
    end
    chk("fwd_hold", {m_stb, m_we, m_sel, m_adr, 13'd0}, {oh, w, s, a[9:0], 13'd0});
    chk("fwd_hold_dat", m_dat, d);
    if (m_we) begin
      slave_mem[p][m_adr[3:0]] = (slave_mem[p][m_adr[3:0]] & ~bmask(m_sel)) | (m_dat & bmask(m_sel));
    end else begin
      m_dat_i[32*p +: 32] = slave_mem[p][m_adr[3:0]];
    end
    m_ack = oh | 4'($urandom);
    @(negedge clk);
    m_ack = 4'($urandom) & ~oh;
    chk("resp_stb_drop", 32'(m_stb), 32'd0);
    chk("resp_no_early_ack", 32'(ack_o), 32'd0);
    @(negedge clk);
    chk("resp_ack", {30'd0, ack_o, err}, {30'd0, 1'b1, 1'b0});
    chk("resp_dat", dat_o, exp_d);
    stb = 1'b0; cyc = 1'b0;
    @(negedge clk);
    chk("resp_ack_pulse", 32'(ack_o), 32'd0);
    m_ack = '0;
  endtask

  initial begin
    int          hi, acks;
    logic [31:0] v;
    rst_n = 1'b0;
    stb = 0; cyc = 0; we = 0; sel = 0; dat = 0; adr = 0;
    stb3 = 0; cyc3 = 0;
    m_ack = '0; m_dat_i = '0; m3_ack = '0; m3_dat_i = '0;
    for (int p = 0; p < 4; p++)
      for (int a = 0; a < 16; a++) begin
        v = $urandom;
        model_mem[p][a] = v;
        slave_mem[p][a] = v;
      end
    model_mem[1][4] = 32'h1234_5678;
    slave_mem[1][4] = 32'h1234_5678;

    repeat (3) @(negedge clk);
    chk("reset_outs", {ack_o, err, m_stb, m_cyc, m_we, m_sel, m_adr}, 32'd0);
    chk("reset_dat", dat_o | m_dat, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Directed read of port 1 and write of port 3.
    xfer(32'h3001_0004, 1'b0, 32'd0, 4'hF, 0);
    chk("read_0x12345678", dat_o, 32'h1234_5678);
    xfer(32'h3003_0010, 1'b1, 32'hA5A5_A5A5, 4'b0011, 0);
    chk("write_slave_mem", slave_mem[3][0] & 32'h0000_FFFF, 32'h0000_A5A5);

    // Randomized traffic against the memory model.
    for (int t = 0; t < 24; t++) begin
      xfer(mk_adr(int'($urandom_range(3, 0)), 10'($urandom)), 1'($urandom),
           $urandom, 4'($urandom), int'($urandom_range(3, 0)));
    end

    // Out-of-range port index on the three-port instance.
    @(negedge clk);
    stb3 = 1; cyc3 = 1; we = 0; adr = 32'h3003_0000;
    @(negedge clk);
    chk("bad_idx_no_stb", {29'd0, m3_stb}, 32'd0);
    chk("bad_idx_wait", {30'd0, ack3, err3}, 32'd0);
    @(negedge clk);
    chk("bad_idx_ack_err", {30'd0, ack3, err3}, 32'd3);
    chk("bad_idx_dat", dat3, 32'hDEAD_BEEF);
    stb3 = 0; cyc3 = 0;
    @(negedge clk);
    chk("bad_idx_err_pulse", {30'd0, ack3, err3}, 32'd0);

    // Base mismatch: ignored entirely.
    stb3 = 1; cyc3 = 1; adr = 32'h2000_0000;
    acks = 0;
    repeat (6) begin
      @(negedge clk);
      if (ack3 || err3 || m3_stb != 3'd0) acks++;
    end
    chk("base_miss_ignored", 32'(acks), 32'd0);
    stb3 = 0; cyc3 = 0;

    // Port 2 never acks.
    @(negedge clk);
    stb = 1; cyc = 1; we = 0; adr = 32'h3002_0000; m_ack = '0;
    @(negedge clk);
`ifdef WB_BRIDGE_TIMEOUT_EN
    hi = 0;
    for (int i = 0; i < 64; i++) begin
      if (m_stb == 4'b0100) hi++;
      @(negedge clk);
    end
    chk("tmo_stb_cycles", 32'(hi), 32'd64);
    chk("tmo_stb_drop", {27'd0, m_stb, ack_o}, 32'd0);
    @(negedge clk);
    chk("tmo_ack_err", {30'd0, ack_o, err}, 32'd3);
    chk("tmo_dat", dat_o, 32'hDEAD_BEEF);
    stb = 0; cyc = 0;
    @(negedge clk);
    chk("tmo_err_pulse", 32'(err), 32'd0);
`else
    hi = 0; acks = 0;
    for (int i = 0; i < 1000; i++) begin
      if (m_stb == 4'b0100) hi++;
      if (ack_o || err) acks++;
      @(negedge clk);
    end
    chk("hold_stb_cycles", 32'(hi), 32'd1000);
    chk("hold_no_ack", 32'(acks), 32'd0);
    stb = 0; cyc = 0;
    @(negedge clk);
    chk("hold_abort_drop", 32'(m_stb), 32'd0);
`endif

    // Abort three cycles into FWD; a late port-0 ack must be ignored.
    @(negedge clk);
    stb = 1; cyc = 1; we = 0; adr = 32'h3000_0008;
    hi = 0;
    repeat (3) begin
      @(negedge clk);
      if (m_stb == 4'b0001) hi++;
    end
    chk("abort_fwd_cycles", 32'(hi), 32'd3);
    stb = 0; cyc = 0;
    @(negedge clk);
    chk("abort_stb_drop", 32'(m_stb), 32'd0);
    m_ack = 4'b0001;
    acks = 0;
    repeat (3) begin
      @(negedge clk);
      if (ack_o || err) acks++;
    end
    chk("abort_no_ack", 32'(acks), 32'd0);
    m_ack = '0;

    // Reset in the middle of FWD.
    @(negedge clk);
    stb = 1; cyc = 1; we = 1; sel = 4'hF; dat = 32'hCAFE_F00D; adr = 32'h3002_0005;
    repeat (2) @(negedge clk);
    chk("pre_rst_fwd", 32'(m_stb), 32'h4);
    rst_n = 1'b0;
    #1;
    chk("rst_async_outs", {ack_o, err, m_stb, m_cyc, m_we, m_sel, m_adr}, 32'd0);
    chk("rst_async_dat", dat_o | m_dat, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    we = 0; adr = 32'h3001_0008;
    @(negedge clk);
    chk("rst_rel_edge1", 32'(m_stb), 32'd0);
    @(negedge clk);
    chk("rst_rel_edge2", 32'(m_stb), 32'h2);
    stb = 0; cyc = 0;
    @(negedge clk);
    chk("rst_rel_abort", 32'(m_stb | {3'd0, ack_o}), 32'd0);
    xfer(32'h3001_0004, 1'b0, 32'd0, 4'hF, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/wb_bridge_nway.md
WB_BRIDGE_NWAY -- requirements
Module: wb_bridge_nway

Interface
REQ-001 Parameter NUM_PORTS, default 4: downstream Wishbone port count, legal 2..8.
REQ-002 Parameter PORT_ADDR_WIDTH, default 10: width of the downstream address, legal 2..16.
REQ-003 Parameter SEL_LSB, default 16: LSB of the port-index field in wbs_adr_i; field width SELW = clog2(NUM_PORTS); legal range SEL_LSB >= PORT_ADDR_WIDTH.
REQ-004 Parameter BASE_ADDR, default 32'h3000_0000: compared against wbs_adr_i[31:SEL_LSB+SELW].
REQ-005 Parameter TIMEOUT_CYCLES, default 64: downstream wait limit, legal 2..1023.
REQ-006 vccd1/vssd1  inout  1  power pins, present only under USE_POWER_PINS.
REQ-007 wb_clk_i  in  1  sole clock; every flop on its rising edge.
REQ-008 wb_rst_ni  in  1  reset, asynchronous assert, active-low.
REQ-009 wbs_stb_i, wbs_cyc_i, wbs_we_i  in  1 each  upstream Wishbone classic controls.
REQ-010 wbs_sel_i  in  4; wbs_dat_i  in  32; wbs_adr_i  in  32  upstream request fields.
REQ-011 wbs_ack_o  out  1; wbs_dat_o  out  32  upstream response.
REQ-012 wbm_stb_o, wbm_cyc_o  out  NUM_PORTS  per-port strobe/cycle, one-hot or zero.
REQ-013 wbm_we_o  out  1; wbm_sel_o  out  4; wbm_dat_o  out  32; wbm_adr_o  out  PORT_ADDR_WIDTH  shared request fields.
REQ-014 wbm_ack_i  in  NUM_PORTS; wbm_dat_i  in  32*NUM_PORTS (port k at bits [32k+31:32k])  per-port response.
REQ-015 err_o  out  1  one-cycle pulse on any error-terminated transfer.

Function
REQ-016 FSM states IDLE, FWD, RESP; all outputs registered.
REQ-017 IDLE: stb&cyc high and base match -> latch we/sel/dat, adr[PORT_ADDR_WIDTH-1:0], idx = adr[SEL_LSB+:SELW]; base mismatch -> ignored, stay IDLE, no ack.
REQ-018 IDLE, base match, idx >= NUM_PORTS -> RESP with wbs_dat_o=32'hDEAD_BEEF, err_o=1; no downstream strobe.
REQ-019 IDLE, valid idx -> FWD; wbm_stb_o[idx]/wbm_cyc_o[idx] high from the following cycle until the cycle after wbm_ack_i[idx] is sampled.
REQ-020 FWD: wbm_ack_i[idx] sampled high -> latch wbm_dat_i of port idx (write: latch 0), drop strobe/cycle, -> RESP.
REQ-021 Acks from unselected ports SHALL be ignored in every state.
REQ-022 RESP: wbs_ack_o high exactly one cycle, then IDLE; wbs_dat_o holds value until next RESP.
REQ-023 Latency: request sampled at edge N, downstream strobe visible after N, slave ack same cycle -> wbs_ack_o high after edge N+2.
REQ-024 FWD, wbs_cyc_i low (abort) -> drop downstream strobe/cycle next edge, IDLE, no wbs_ack_o, no err_o.
REQ-025 Downstream request fields SHALL hold stable throughout FWD regardless of upstream changes.
REQ-026 One transfer outstanding at a time; upstream requests during FWD/RESP are not sampled.

Reset
REQ-027 wb_rst_ni low -> immediately state IDLE, wbs_ack_o=0, wbs_dat_o=0, wbm_stb_o=0, wbm_cyc_o=0, wbm_we_o=0, wbm_sel_o=0, wbm_dat_o=0, wbm_adr_o=0, err_o=0, timeout counter=0.
REQ-028 Reset mid-FWD SHALL abandon the transfer with no upstream ack; deassertion synchronised to wb_clk_i edge, first request sampled on the second edge after release.

Configuration
REQ-029 Macro WB_BRIDGE_TIMEOUT_EN defined: counter clears on FWD entry, increments each FWD cycle; reaching TIMEOUT_CYCLES without ack -> drop downstream strobe/cycle, RESP with 32'hDEAD_BEEF, err_o=1.
REQ-030 Macro undefined: no counter logic; FWD waits indefinitely for ack or abort.

Verification
REQ-031 Read adr 32'h3001_0004 (port 1), slave 1 acks at first strobe cycle with 32'h1234_5678 -> only wbm_stb_o[1], wbm_adr_o=10'h004, wbs_dat_o=32'h1234_5678, ack after 2 edges.
REQ-032 Write adr 32'h3003_0010, dat 32'hA5A5_A5A5, sel 4'b0011 -> wbm_stb_o[3], wbm_dat_o=32'hA5A5_A5A5, wbm_sel_o=4'b0011, we=1, one wbs_ack_o pulse.
REQ-033 Parameter NUM_PORTS=3, adr 32'h3003_0000 -> no downstream strobe, wbs_dat_o=32'hDEAD_BEEF, err_o pulse; adr 32'h2000_0000 -> no response.
REQ-034 WB_BRIDGE_TIMEOUT_EN, port 2 never acks -> strobe dropped after 64 FWD cycles, 32'hDEAD_BEEF, err_o; macro undefined -> strobe held 1000 cycles, no ack.
REQ-035 Abort: cyc_i low 3 cycles into FWD, port 0 acks later -> no wbs_ack_o; reset pulse mid-FWD -> all outputs 0 at once, next read completes normally.
